// File: rtl/alu_seq.sv
// Registered W-bit ALU with accumulator feedback and a shift-add multiplier; single-cycle ops land 1 edge after accept, MUL W+1 edges.
// No backpressure: start is accepted only in IDLE, so requests while busy are dropped and the caller must watch busy/done.
module alu_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         c_in,
    input  logic         use_acc,
    output logic [W-1:0] R,
    output logic [W-1:0] R_hi,
    output logic         zero,
    output logic         c_out,
    output logic         sign,
    output logic         ovf,
    output logic         busy,
    output logic         done
);

    localparam logic [3:0] OP_MUL = 4'b1001;
    localparam int CW = $clog2(W) + 1;

    typedef enum logic {IDLE, MUL} state_t;

    state_t         state, state_nx;
    logic [W-1:0]   mcand, mcand_nx;
    logic [2*W-1:0] prod, prod_nx, prod_step;
    logic [CW-1:0]  cnt, cnt_nx;

    logic [W-1:0]   r_nx, r_hi_nx;
    logic           zero_nx, c_out_nx, sign_nx, ovf_nx, busy_nx, done_nx;

    logic [W-1:0]   aeff, op1, op2, lres;
    logic [W:0]     add_s, mul_sum;
    logic           is_add, is_logic;

    assign aeff = use_acc ? R : A;

    always_comb begin
        op1      = '0;
        op2      = '0;
        lres     = '0;
        is_add   = 1'b1;
        is_logic = 1'b0;
        case (op)
            4'b0000: op2 = aeff;
            4'b0001: begin op1 = W'(1); op2 = ~aeff; end
            4'b0010: begin op1 = aeff;  op2 = B;     end
            4'b0011: begin op1 = W'(1); op2 = aeff;  end
            4'b1000: begin op1 = aeff;  op2 = ~B;    end
            default: is_add = 1'b0;
        endcase
        case (op)
            4'b0100: begin is_logic = 1'b1; lres = aeff & B; end
            4'b0101: begin is_logic = 1'b1; lres = aeff | B; end
            4'b0110: begin is_logic = 1'b1; lres = aeff ^ B; end
            4'b0111: begin is_logic = 1'b1; lres = ~aeff;    end
            default: ;
        endcase
    end

    assign add_s = {1'b0, op1} + {1'b0, op2} + {{W{1'b0}}, c_in};

    // One shift-add step: the multiplier sits in the low half and is consumed LSB first.
    assign mul_sum   = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, mcand} : {(W+1){1'b0}});
    assign prod_step = {mul_sum, prod[W-1:1]};

    always_comb begin
        state_nx = state;
        mcand_nx = mcand;
        prod_nx  = prod;
        cnt_nx   = cnt;
        r_nx     = R;
        r_hi_nx  = R_hi;
        zero_nx  = zero;
        c_out_nx = c_out;
        sign_nx  = sign;
        ovf_nx   = ovf;
        busy_nx  = busy;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        mcand_nx = B;
                        prod_nx  = {{W{1'b0}}, aeff};
                        cnt_nx   = '0;
                        busy_nx  = 1'b1;
                        state_nx = MUL;
                    end else begin
                        done_nx = 1'b1;
                        if (is_add) begin
                            r_nx     = add_s[W-1:0];
                            r_hi_nx  = '0;
                            c_out_nx = add_s[W];
                            ovf_nx   = (op1[W-1] == op2[W-1]) && (add_s[W-1] != op1[W-1]);
                            zero_nx  = (add_s[W-1:0] == '0);
                            sign_nx  = add_s[W-1];
                        end else if (is_logic) begin
                            r_nx     = lres;
                            r_hi_nx  = '0;
                            c_out_nx = 1'b0;
                            ovf_nx   = 1'b0;
                            zero_nx  = (lres == '0);
                            sign_nx  = lres[W-1];
                        end
                        // Reserved codes fall through: outputs hold, done still pulses.
                    end
                end
            end
            MUL: begin
                prod_nx = prod_step;
                cnt_nx  = cnt + 1'b1;
                if (cnt == CW'(W - 1)) begin
                    r_nx     = prod_step[W-1:0];
                    r_hi_nx  = prod_step[2*W-1:W];
                    c_out_nx = 1'b0;
                    ovf_nx   = (prod_step[2*W-1:W] != '0);
                    zero_nx  = (prod_step == '0);
                    sign_nx  = prod_step[W-1];
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            mcand <= '0;
            prod  <= '0;
            cnt   <= '0;
            R     <= '0;
            R_hi  <= '0;
            zero  <= 1'b1;
            c_out <= 1'b0;
            sign  <= 1'b0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            mcand <= mcand_nx;
            prod  <= prod_nx;
            cnt   <= cnt_nx;
            R     <= r_nx;
            R_hi  <= r_hi_nx;
            zero  <= zero_nx;
            c_out <= c_out_nx;
            sign  <= sign_nx;
            ovf   <= ovf_nx;
            busy  <= busy_nx;
            done  <= done_nx;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vectors then random ops, all against an integer-arithmetic reference model.
module tb_alu_seq;

    localparam int W = 8;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         reset, start, c_in, use_acc;
    logic [3:0]   op;
    logic [W-1:0] A, B;
    logic [W-1:0] R, R_hi;
    logic         zero, c_out, sign, ovf, busy, done;

    int n_chk = 0;
    int n_bad = 0;

    // Reference state: what the visible outputs should be right now.
    int m_r = 0, m_hi = 0, m_z = 1, m_c = 0, m_s = 0, m_v = 0;

    alu_seq #(.W(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .c_in(c_in), .use_acc(use_acc), .R(R), .R_hi(R_hi), .zero(zero),
        .c_out(c_out), .sign(sign), .ovf(ovf), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sx(input int x);
        return (x >= M / 2) ? x - M : x;
    endfunction

    task automatic model_op(input int o, input int a, input int b, input int ci, input int ua);
        int aeff, op1, op2, s, sv, p;
        aeff = (ua != 0) ? m_r : a;
        op1 = 0;
        op2 = 0;
        if (o inside {0, 1, 2, 3, 8}) begin
            case (o)
                0:       begin op1 = 0;    op2 = aeff;         end
                1:       begin op1 = 1;    op2 = M - 1 - aeff; end
                2:       begin op1 = aeff; op2 = b;            end
                3:       begin op1 = 1;    op2 = aeff;         end
                default: begin op1 = aeff; op2 = M - 1 - b;    end
            endcase
            s    = op1 + op2 + ci;
            sv   = sx(op1) + sx(op2) + ci;
            m_r  = s % M;
            m_c  = s / M;
            m_v  = (sv > M / 2 - 1 || sv < -(M / 2)) ? 1 : 0;
            m_hi = 0;
            m_z  = (m_r == 0) ? 1 : 0;
            m_s  = (m_r >= M / 2) ? 1 : 0;
        end else if (o inside {[4:7]}) begin
            case (o)
                4:       m_r = aeff & b;
                5:       m_r = aeff | b;
                6:       m_r = aeff ^ b;
                default: m_r = M - 1 - aeff;
            endcase
            m_c  = 0;
            m_v  = 0;
            m_hi = 0;
            m_z  = (m_r == 0) ? 1 : 0;
            m_s  = (m_r >= M / 2) ? 1 : 0;
        end else if (o == 9) begin
            p    = aeff * b;
            m_r  = p % M;
            m_hi = p / M;
            m_c  = 0;
            m_v  = (m_hi != 0) ? 1 : 0;
            m_z  = (p == 0) ? 1 : 0;
            m_s  = (m_r >= M / 2) ? 1 : 0;
        end
    endtask

    task automatic check_outs(input string tag);
        chk_eq({tag, ".R"},     32'(R),    m_r);
        chk_eq({tag, ".R_hi"},  32'(R_hi), m_hi);
        chk_eq({tag, ".flags"}, 32'({zero, c_out, sign, ovf}), 32'(m_z * 8 + m_c * 4 + m_s * 2 + m_v));
        chk_eq({tag, ".done"},  32'(done), 32'd1);
        chk_eq({tag, ".busy"},  32'(busy), 32'd0);
    endtask

    // Called #1 after a clock edge; returns #1 after the edge where done is expected.
    task automatic do_op(input string tag, input int o, input int a, input int b, input int ci, input int ua);
        int n, old_r;
        old_r   = m_r;
        start   = 1'b1;
        op      = o[3:0];
        A       = a[W-1:0];
        B       = b[W-1:0];
        c_in    = ci[0];
        use_acc = ua[0];
        @(posedge clk); #1;
        start = 1'b0;
        if (o == 9) begin
            chk_eq({tag, ".busy0"}, 32'(busy), 32'd1);
            chk_eq({tag, ".hold"},  32'(R), 32'(old_r));
            n = 0;
            while (busy === 1'b1 && n < 40) begin
                n++;
                start   = 1'($urandom_range(0, 1));
                op      = 4'($urandom);
                A       = W'($urandom);
                B       = W'($urandom);
                use_acc = 1'($urandom);
                @(posedge clk); #1;
            end
            start = 1'b0;
            chk_eq({tag, ".busy_cycles"}, 32'(n), 32'(W));
        end
        model_op(o, a, b, ci, ua);
        check_outs(tag);
    endtask

    task automatic idle_chk(input string tag);
        start = 1'b0;
        @(posedge clk); #1;
        chk_eq({tag, ".done_lo"}, 32'(done), 32'd0);
        chk_eq({tag, ".R_held"},  32'(R), m_r);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        op      = '0;
        A       = '0;
        B       = '0;
        c_in    = 1'b0;
        use_acc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_eq("rst.R",     32'(R), 32'd0);
        chk_eq("rst.R_hi",  32'(R_hi), 32'd0);
        chk_eq("rst.flags", 32'({zero, c_out, sign, ovf}), 32'b1000);
        chk_eq("rst.busy",  32'(busy), 32'd0);
        chk_eq("rst.done",  32'(done), 32'd0);

        do_op("add", 2, 'h7F, 'h01, 0, 0);
        chk_eq("add.R_lit", 32'(R), 32'h80);
        chk_eq("add.flags_lit", 32'({zero, c_out, sign, ovf}), 32'b0011);
        idle_chk("add_gap");
        do_op("sub", 8, 'h05, 'h05, 1, 0);
        chk_eq("sub.flags_lit", 32'({zero, c_out, sign, ovf}), 32'b1100);
        do_op("neg", 1, 'h01, 'h00, 0, 0);
        chk_eq("neg.R_lit", 32'(R), 32'hFF);
        do_op("mul1", 9, 'h0F, 'h11, 0, 0);
        chk_eq("mul1.R_lit", 32'(R), 32'hFF);
        do_op("mul2", 9, 'hFF, 'hFF, 0, 0);
        chk_eq("mul2.hi_lit", 32'(R_hi), 32'hFE);
        do_op("mul_z", 9, 'h10, 'h10, 0, 0);
        do_op("add2", 2, 'h7F, 'h01, 0, 0);
        do_op("inc_acc", 3, 'h55, 'h00, 0, 1);
        chk_eq("inc_acc.R_lit", 32'(R), 32'h81);
        do_op("not_acc", 7, 'h55, 'h00, 0, 1);
        chk_eq("not_acc.R_lit", 32'(R), 32'h7E);
        do_op("and", 4, 'hF0, 'h3C, 1, 0);
        do_op("or",  5, 'hF0, 'h3C, 1, 0);
        do_op("xor", 6, 'hF0, 'h3C, 1, 0);
        do_op("not", 7, 'hF0, 'h3C, 1, 0);
        chk_eq("not.R_lit", 32'(R), 32'h0F);
        do_op("rsv", 15, 'h12, 'h34, 1, 0);
        chk_eq("rsv.R_lit", 32'(R), 32'h0F);
        idle_chk("rsv_gap");

        for (int i = 0; i < 150; i++) begin
            do_op("rnd", int'($urandom_range(0, 15)), int'($urandom_range(0, M - 1)),
                  int'($urandom_range(0, M - 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle_chk("rnd_gap");
        end

        // Abort a multiply part way through.
        start   = 1'b1;
        op      = 4'b1001;
        A       = 8'h37;
        B       = 8'h5A;
        use_acc = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk_eq("abort.busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_r = 0; m_hi = 0; m_z = 1; m_c = 0; m_s = 0; m_v = 0;
        chk_eq("abort.R",     32'(R), 32'd0);
        chk_eq("abort.R_hi",  32'(R_hi), 32'd0);
        chk_eq("abort.flags", 32'({zero, c_out, sign, ovf}), 32'b1000);
        chk_eq("abort.busy",  32'(busy), 32'd0);
        chk_eq("abort.done",  32'(done), 32'd0);
        @(posedge clk); #1;
        chk_eq("abort.done2", 32'(done), 32'd0);
        chk_eq("abort.busy2", 32'(busy), 32'd0);

        // Reset and start on the same edge: reset must win.
        start = 1'b1;
        op    = 4'b0010;
        A     = 8'h11;
        B     = 8'h22;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        chk_eq("rst_start.R",    32'(R), 32'd0);
        chk_eq("rst_start.done", 32'(done), 32'd0);
        chk_eq("rst_start.busy", 32'(busy), 32'd0);

        do_op("post", 2, 'h03, 'h04, 1, 0);
        do_op("post_mul", 9, 'hA5, 'h3C, 0, 0);
        idle_chk("post_gap");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
